// File: rtl/dff_mem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// dff_mem_arbiter_pkg
//
// Shared definitions for the DFF RAM arbiter slice: default bus widths,
// requester identifiers, the command record a requester presents, and the
// tag that follows a read through the RAM pipeline.
// ----------------------------------------------------------------------------
package dff_mem_arbiter_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    typedef struct packed {
        logic                  we;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;

endpackage

// File: rtl/dff_mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// dff_mem_arbiter_if
//
// One requester's command/response bundle.
//   req/we/addr/wdata : command, driven by the requester (valid/ready style)
//   gnt               : command accepted at this edge, driven by the arbiter
//   rvalid/rdata      : one-cycle read return, driven by the arbiter
// master = requester side, slave = arbiter side.
// ----------------------------------------------------------------------------
interface dff_mem_arbiter_if
    import dff_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/dff_mem_rr_pick.sv
// ----------------------------------------------------------------------------
// dff_mem_rr_pick
//
// Two-way round-robin grant logic with its priority pointer.
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : when low no grant is issued
//   req[1:0]   : request vector, bit index = requester id
//   gnt[1:0]   : one-hot (or zero) combinational grant
// ----------------------------------------------------------------------------
module dff_mem_rr_pick
    import dff_mem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // Id of the requester that wins when both ask at once.
    logic ptr;

    always_comb begin
        gnt = 2'b00;
        if (ena) begin
            if (req[0] && req[1]) begin
                gnt[ptr] = 1'b1;
            end else begin
                gnt = req;
            end
        end
    end

    // After any grant the tie-break passes to the requester that lost, so a
    // continuously requesting loser waits at most one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= REQ_A;
        end else if (gnt[REQ_A]) begin
            ptr <= REQ_B;
        end else if (gnt[REQ_B]) begin
            ptr <= REQ_A;
        end
    end

endmodule

// File: rtl/dff_mem_arbiter.sv
// ----------------------------------------------------------------------------
// dff_mem_arbiter
//
// Round-robin arbiter and sequencer placing two requesters onto the single
// port of the 16x8 DFF RAM macro.
//   clk, rst_n          : clock, asynchronous active-low reset
//   ena                 : design enable, no grants while low
//   a_if, b_if          : requester command/response bundles (slave side)
//   mem_ce_n            : RAM chip enable / read strobe, active low
//   mem_lr_n            : RAM write strobe, active low
//   mem_addr, mem_wdata : RAM address and write data
//   mem_rdata           : RAM registered read data
// Timing: accept edge E0 registers the strobes, the RAM acts at E1 and the
// read data is returned with a one-cycle rvalid at E2.
// ----------------------------------------------------------------------------
module dff_mem_arbiter
    import dff_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    dff_mem_arbiter_if.slave  a_if,
    dff_mem_arbiter_if.slave  b_if,
    output logic              mem_ce_n,
    output logic              mem_lr_n,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [1:0]        req;
    logic [1:0]        gnt;
    logic              acc_valid;
    logic              acc_id;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;

    tag_t              issue_tag;
    tag_t              ram_tag;

    logic              a_rvalid_q;
    logic              b_rvalid_q;
    logic [DATA_W-1:0] a_rdata_q;
    logic [DATA_W-1:0] b_rdata_q;

    assign req = {b_if.req, a_if.req};

    dff_mem_rr_pick u_pick (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .req   (req),
        .gnt   (gnt)
    );

    assign a_if.gnt = gnt[REQ_A];
    assign b_if.gnt = gnt[REQ_B];

    // Select the accepted command; grants never depend on these fields.
    always_comb begin
        acc_valid = |gnt;
        acc_id    = gnt[REQ_B] ? REQ_B : REQ_A;
        if (acc_id == REQ_B) begin
            acc_we    = b_if.we;
            acc_addr  = b_if.addr;
            acc_wdata = b_if.wdata;
        end else begin
            acc_we    = a_if.we;
            acc_addr  = a_if.addr;
            acc_wdata = a_if.wdata;
        end
    end

    // The RAM writes whenever lr_n is low, even with ce_n high, so lr_n is
    // only driven low for a cycle that carries an accepted write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_ce_n  <= 1'b1;
            mem_lr_n  <= 1'b1;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_ce_n <= !(acc_valid && !acc_we);
            mem_lr_n <= !(acc_valid && acc_we);
            if (acc_valid) begin
                mem_addr  <= acc_addr;
                mem_wdata <= acc_wdata;
            end
        end
    end

    // issue_tag lines up with the strobes, ram_tag with the RAM output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_tag <= '0;
            ram_tag   <= '0;
        end else begin
            issue_tag.valid <= acc_valid && !acc_we;
            issue_tag.id    <= acc_id;
            ram_tag         <= issue_tag;
        end
    end

    // rdata holds between returns; rvalid is a single-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            a_rvalid_q <= ram_tag.valid && (ram_tag.id == REQ_A);
            b_rvalid_q <= ram_tag.valid && (ram_tag.id == REQ_B);
            if (ram_tag.valid && (ram_tag.id == REQ_A)) begin
                a_rdata_q <= mem_rdata;
            end
            if (ram_tag.valid && (ram_tag.id == REQ_B)) begin
                b_rdata_q <= mem_rdata;
            end
        end
    end

    assign a_if.rvalid = a_rvalid_q;
    assign b_if.rvalid = b_rvalid_q;
    assign a_if.rdata  = a_rdata_q;
    assign b_if.rdata  = b_rdata_q;

endmodule

// File: tb/tb_dff_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dff_mem_arbiter
//
// Bench for dff_mem_arbiter with a behavioural RAM, a transaction-level
// model of the arbiter and directed stimulus with literal expectations.
// ----------------------------------------------------------------------------
module tb_dff_mem_arbiter;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       mem_ce_n;
    logic       mem_lr_n;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 0;

    dff_mem_arbiter_if #(.ADDR_W(4), .DATA_W(8)) a_if ();
    dff_mem_arbiter_if #(.ADDR_W(4), .DATA_W(8)) b_if ();

    dff_mem_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .a_if      (a_if),
        .b_if      (b_if),
        .mem_ce_n  (mem_ce_n),
        .mem_lr_n  (mem_lr_n),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM macro: writes on lr_n low regardless of ce_n, registered read.
    logic [7:0] ram [16];
    always @(posedge clk) begin
        if (!mem_lr_n) ram[mem_addr] <= mem_wdata;
        if (!mem_ce_n) mem_rdata <= ram[mem_addr];
    end

    // ------------------------------------------------------------------
    // Transaction-level model
    // ------------------------------------------------------------------
    typedef struct {
        int         id;
        logic [7:0] data;
        int         due;
    } ret_t;

    ret_t       inflight[$];
    logic [7:0] shadow [16];
    int         cyc;
    int         turn;
    bit         pend_wr;
    logic [3:0] pend_addr;
    logic [7:0] pend_data;
    logic       exp_ce_n, exp_lr_n;
    logic [3:0] exp_addr;
    logic [7:0] exp_wdata;
    logic       exp_a_rvalid, exp_b_rvalid;
    logic [7:0] exp_a_rdata, exp_b_rdata;

    function automatic int modelWinner();
        if (!ena) return -1;
        if (a_if.req && b_if.req) return turn;
        if (a_if.req) return 0;
        if (b_if.req) return 1;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int   win;
        ret_t r;
        if (!rst_n) begin
            inflight.delete();
            cyc          = 0;
            turn         = 0;
            pend_wr      = 0;
            exp_ce_n     = 1'b1;
            exp_lr_n     = 1'b1;
            exp_addr     = '0;
            exp_wdata    = '0;
            exp_a_rvalid = 1'b0;
            exp_b_rvalid = 1'b0;
            exp_a_rdata  = '0;
            exp_b_rdata  = '0;
        end else begin
            cyc++;
            if (pend_wr) shadow[pend_addr] = pend_data;
            pend_wr      = 0;
            exp_a_rvalid = 1'b0;
            exp_b_rvalid = 1'b0;
            while (inflight.size() > 0 && inflight[0].due == cyc) begin
                r = inflight.pop_front();
                if (r.id == 0) begin
                    exp_a_rvalid = 1'b1;
                    exp_a_rdata  = r.data;
                end else begin
                    exp_b_rvalid = 1'b1;
                    exp_b_rdata  = r.data;
                end
            end
            win      = modelWinner();
            exp_ce_n = 1'b1;
            exp_lr_n = 1'b1;
            if (win >= 0) begin
                logic       we;
                logic [3:0] ad;
                logic [7:0] wd;
                we = (win == 0) ? a_if.we    : b_if.we;
                ad = (win == 0) ? a_if.addr  : b_if.addr;
                wd = (win == 0) ? a_if.wdata : b_if.wdata;
                exp_addr = ad;
                if (we) begin
                    exp_lr_n  = 1'b0;
                    exp_wdata = wd;
                    pend_wr   = 1;
                    pend_addr = ad;
                    pend_data = wd;
                end else begin
                    exp_ce_n = 1'b0;
                    r.id   = win;
                    r.data = shadow[ad];
                    r.due  = cyc + 2;
                    inflight.push_back(r);
                end
                turn = 1 - win;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (cmp_on) begin
            int w;
            w = rst_n ? modelWinner() : -1;
            checkOutput("a_gnt", a_if.gnt, (w == 0));
            checkOutput("b_gnt", b_if.gnt, (w == 1));
            checkOutput("mem_ce_n", mem_ce_n, exp_ce_n);
            checkOutput("mem_lr_n", mem_lr_n, exp_lr_n);
            if (!exp_lr_n || !exp_ce_n) checkOutput("mem_addr", mem_addr, exp_addr);
            if (!exp_lr_n) checkOutput("mem_wdata", mem_wdata, exp_wdata);
            checkOutput("a_rvalid", a_if.rvalid, exp_a_rvalid);
            checkOutput("b_rvalid", b_if.rvalid, exp_b_rvalid);
            checkOutput("a_rdata", a_if.rdata, exp_a_rdata);
            checkOutput("b_rdata", b_if.rdata, exp_b_rdata);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers; callers sit just after a rising edge.
    // ------------------------------------------------------------------
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int id, input logic we, input logic [3:0] addr,
                                 input logic [7:0] wdata);
        bit got;
        got = 0;
        if (id == 0) begin
            a_if.we = we; a_if.addr = addr; a_if.wdata = wdata; a_if.req = 1'b1;
        end else begin
            b_if.we = we; b_if.addr = addr; b_if.wdata = wdata; b_if.req = 1'b1;
        end
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if ((id == 0 ? a_if.gnt : b_if.gnt) === 1'b1) begin
                got = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        checkOutput("grant_seen", got, 1);
        @(posedge clk);
        #1;
        if (id == 0) a_if.req = 1'b0;
        else         b_if.req = 1'b0;
    endtask

    task automatic waitRvalid(input int id, output int edges);
        edges = -1;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk);
            @(negedge clk);
            if ((id == 0 ? a_if.rvalid : b_if.rvalid) === 1'b1) begin
                edges = n;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int e;
        int a_cnt;
        int b_cnt;
        rst_n = 1'b0;
        ena   = 1'b1;
        a_if.req = 1'b0; a_if.we = 1'b0; a_if.addr = '0; a_if.wdata = '0;
        b_if.req = 1'b0; b_if.we = 1'b0; b_if.addr = '0; b_if.wdata = '0;

        // Reset values.
        @(posedge clk);
        cmp_on = 1;
        @(negedge clk);
        checkOutput("rst_ce_n", mem_ce_n, 1);
        checkOutput("rst_lr_n", mem_lr_n, 1);
        checkOutput("rst_addr", mem_addr, 0);
        checkOutput("rst_wdata", mem_wdata, 0);
        checkOutput("rst_a_rdata", a_if.rdata, 0);
        checkOutput("rst_b_rvalid", b_if.rvalid, 0);
        nextCycle();
        rst_n = 1'b1;
        nextCycle();

        // A writes 0xA5 to address 3.
        applyStimulus(0, 1'b1, 4'd3, 8'hA5);
        @(negedge clk);
        checkOutput("wr_lr_n", mem_lr_n, 0);
        checkOutput("wr_ce_n", mem_ce_n, 1);
        checkOutput("wr_addr", mem_addr, 3);
        checkOutput("wr_wdata", mem_wdata, 8'hA5);
        nextCycle();
        @(negedge clk);
        checkOutput("wr_lr_n_released", mem_lr_n, 1);
        nextCycle();

        // A reads address 3 back.
        applyStimulus(0, 1'b0, 4'd3, 8'h00);
        waitRvalid(0, e);
        checkOutput("a_rd_latency", e, 2);
        checkOutput("a_rd_data", a_if.rdata, 8'hA5);
        nextCycle();

        // Preload addresses 1 and 2; the B write leaves priority with A.
        applyStimulus(0, 1'b1, 4'd1, 8'h11);
        applyStimulus(1, 1'b1, 4'd2, 8'h22);
        nextCycle();

        // Both request reads continuously.
        a_if.we = 1'b0; a_if.addr = 4'd1; a_if.req = 1'b1;
        b_if.we = 1'b0; b_if.addr = 4'd2; b_if.req = 1'b1;
        a_cnt = 0;
        b_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("alt_a_gnt", a_if.gnt, (i % 2) == 0);
            checkOutput("alt_b_gnt", b_if.gnt, (i % 2) == 1);
            a_cnt += int'(a_if.rvalid);
            b_cnt += int'(b_if.rvalid);
            nextCycle();
        end
        a_if.req = 1'b0;
        b_if.req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a_cnt += int'(a_if.rvalid);
            b_cnt += int'(b_if.rvalid);
            nextCycle();
        end
        checkOutput("alt_a_returns", a_cnt, 3);
        checkOutput("alt_b_returns", b_cnt, 3);
        checkOutput("alt_a_rdata", a_if.rdata, 8'h11);
        checkOutput("alt_b_rdata", b_if.rdata, 8'h22);

        // B writes then reads address 7 back to back.
        applyStimulus(1, 1'b1, 4'd7, 8'h3C);
        applyStimulus(1, 1'b0, 4'd7, 8'h00);
        waitRvalid(1, e);
        checkOutput("b_rd_latency", e, 2);
        checkOutput("b_rd_data", b_if.rdata, 8'h3C);
        nextCycle();

        // Idle, then ena low with both requesting.
        nextCycle();
        ena = 1'b0;
        a_if.we = 1'b1; a_if.addr = 4'd3; a_if.wdata = 8'hFF; a_if.req = 1'b1;
        b_if.we = 1'b0; b_if.addr = 4'd2; b_if.req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("dis_a_gnt", a_if.gnt, 0);
            checkOutput("dis_b_gnt", b_if.gnt, 0);
            checkOutput("dis_lr_n", mem_lr_n, 1);
            checkOutput("dis_ce_n", mem_ce_n, 1);
            nextCycle();
        end
        a_if.req = 1'b0;
        b_if.req = 1'b0;
        ena = 1'b1;
        applyStimulus(0, 1'b0, 4'd3, 8'h00);
        waitRvalid(0, e);
        checkOutput("dis_readback", a_if.rdata, 8'hA5);
        nextCycle();

        // ena falls right after a read is accepted.
        applyStimulus(0, 1'b0, 4'd1, 8'h00);
        ena = 1'b0;
        waitRvalid(0, e);
        checkOutput("ena_fall_latency", e, 2);
        checkOutput("ena_fall_data", a_if.rdata, 8'h11);
        nextCycle();
        ena = 1'b1;

        // Reset one cycle after a read is accepted.
        applyStimulus(0, 1'b0, 4'd2, 8'h00);
        nextCycle();
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst_ce_n", mem_ce_n, 1);
        checkOutput("mid_rst_a_rvalid", a_if.rvalid, 0);
        checkOutput("mid_rst_a_rdata", a_if.rdata, 0);
        nextCycle();
        rst_n = 1'b1;
        a_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a_cnt += int'(a_if.rvalid);
            nextCycle();
        end
        checkOutput("no_rvalid_after_rst", a_cnt, 0);

        // Priority is back with A.
        a_if.we = 1'b0; a_if.addr = 4'd1; a_if.req = 1'b1;
        b_if.we = 1'b0; b_if.addr = 4'd2; b_if.req = 1'b1;
        @(negedge clk);
        checkOutput("ptr_rst_a_gnt", a_if.gnt, 1);
        checkOutput("ptr_rst_b_gnt", b_if.gnt, 0);
        nextCycle();
        a_if.req = 1'b0;
        b_if.req = 1'b0;
        repeat (5) nextCycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dff_mem_arbiter.md
Name: dff_mem_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the 16x8 DFF RAM macro, which has a single shared port.
- Each requester uses a valid/ready (req/gnt) command interface.
- The arbiter drives the RAM's active-low chip-enable and active-low write strobe (lr_n), plus address and write data.
- Read data is tracked through a 2-stage pipeline and returned to the requester that issued the read.
- Sits between the top-level pin decode and the RAM instance.

Parameters:
- ADDR_W, 4, address width (RAM depth = 2**ADDR_W = 16)
- DATA_W, 8, data width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  design enable; when low, no grants are issued
- a_req  in  1  requester A command valid
- a_we  in  1  A: 1 = write, 0 = read
- a_addr  in  ADDR_W  A address
- a_wdata  in  DATA_W  A write data
- a_gnt  out  1  A command accepted this cycle (combinational)
- a_rvalid  out  1  A read data valid, one-cycle pulse
- a_rdata  out  DATA_W  A read data
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  same as A, for requester B
- mem_ce_n  out  1  RAM chip enable, active low (read strobe)
- mem_lr_n  out  1  RAM write strobe, active low
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM registered read data

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous, active-low, rst_n.
- Reset values:
  - mem_ce_n=1, mem_lr_n=1, mem_addr=0, mem_wdata=0.
  - a_rvalid=b_rvalid=0, a_rdata=b_rdata=0.
  - Pipeline valids cleared; priority pointer = A.
- Grant (combinational):
  - Only one requester asserting req: it is granted.
  - Both asserting req: the pointer holder is granted.
  - Nothing is granted while ena=0.
  - A transfer occurs at a rising edge where req&&gnt.
- Pointer: after a grant, it moves to the non-granted requester. It is unchanged with no grant. A continuously requesting loser waits at most 1 cycle.
- Issue stage: registered at the accept edge E0.
  - Write: mem_lr_n=0, mem_ce_n=1.
  - Read: mem_ce_n=0, mem_lr_n=1.
  - mem_addr and mem_wdata take the winner's fields.
  - With no transfer: mem_ce_n=1 and mem_lr_n=1. mem_lr_n must never be low without an accepted write, because the RAM writes on lr_n low regardless of ce_n.
- RAM action: the RAM acts at E1. A read's data appears on mem_rdata after E1.
- Return stage:
  - At E2, the issuing requester's rdata is loaded from mem_rdata and its rvalid goes high for exactly one cycle.
  - Read latency: accept edge to rvalid visible = 2 edges.
  - Writes produce no rvalid.
  - rdata holds its last value when rvalid is low.
- Pipeline tracking:
  - A 2-entry shift of {valid, id} tracks in-flight reads.
  - Throughput is one command per cycle. Back-to-back reads return in issue order, one per cycle.
- Ordering: a write accepted at E0 followed by a read of the same address accepted at E1 returns the new data.
- Simultaneous A-write and B-read of the same address: only one is granted. The result follows grant order.
- ena falling mid-operation: already-accepted reads still complete and return rvalid.
- rst_n asserted mid-operation:
  - All in-flight reads are discarded (no rvalid).
  - Strobes go inactive immediately, asynchronously.
  - RAM contents are not affected by the arbiter.
- Requester contract: req and the command fields are held stable until gnt is seen at an edge. gnt does not depend on we, addr or wdata.

Decomposition:
- Shared package holds:
  - ADDR_W and DATA_W defaults
  - requester-id constants REQ_A=0, REQ_B=1
  - typedef for the command struct {we, addr, wdata}
  - typedef for the in-flight tag {valid, id}
- One natural sub-module: dff_mem_rr_pick. It is the 2-way round-robin grant logic plus pointer register, and is reusable for more requesters later.
- The RAM itself stays outside; it is instantiated alongside at top level.

Test Plan:
- Reset, then A writes 0xA5 to addr 3 -> at E0+1, mem_lr_n=0, mem_addr=3, mem_wdata=0xA5 for one cycle; mem_ce_n stays 1.
- A reads addr 3 after that write -> a_rvalid pulses once with a_rdata=0xA5, 2 edges after accept; b_rvalid stays 0.
- A and B both hold req continuously (reads of addr 1 and addr 2, preloaded 0x11 and 0x22) -> grants alternate A,B,A,B starting with A; rvalids alternate with 0x11/0x22, one per cycle.
- B writes 0x3C to addr 7, then reads addr 7 on the next cycle -> b_rdata=0x3C.
- Idle cycles, and ena=0 with both req high -> no gnt; mem_lr_n and mem_ce_n stay 1; RAM contents unchanged (read back addr 3 = 0xA5).
- Read accepted, then rst_n pulsed low 1 cycle later -> no rvalid ever; all outputs at reset values during reset; pointer back to A.
